// File: rtl/pc_sequencer.sv
// pc_sequencer
// Fetch/execute sequencer for an 8-bit program counter. It fetches 1- or
// 2-byte instructions over a req/ack memory port and steers the counter's
// control pins. It latches the opcode and operand and issues one-cycle
// execute strobes to the datapath.
//
// Ports:
//   clk       clock
//   rst       asynchronous, active-low reset
//   run       level; start or continue execution
//   mem_ack   memory byte valid, sampled at posedge
//   mem_data  byte returned by memory (valid with mem_ack)
//   mem_req   fetch request; the PC drives the address on bus A
//   pc_mode   counter mode: 0 = increment, 1 = load
//   pc_sel    counter load source: 0 = hold (current PC), 1 = operand (jump)
//   pc_en_a   counter drives bus A (fetch address)
//   pc_en_b   counter drives bus B (GETPC)
//   ir        latched opcode
//   operand   latched second instruction byte
//   alu_go    one-cycle ALU execute strobe
//   ld_go     one-cycle load-immediate strobe
//   busy      sequencer is neither idle nor halted
//   halted    sequencer is halted; only rst leaves this state
module pc_sequencer #(
   parameter logic [7:0] HALT_OP  = 8'hFF,
   parameter logic [7:0] GETPC_OP = 8'hFE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       mem_ack,
   input  logic [7:0] mem_data,
   output logic       mem_req,
   output logic       pc_mode,
   output logic       pc_sel,
   output logic       pc_en_a,
   output logic       pc_en_b,
   output logic [7:0] ir,
   output logic [7:0] operand,
   output logic       alu_go,
   output logic       ld_go,
   output logic       busy,
   output logic       halted
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      OPND  = 3'd2,
      EXEC  = 3'd3,
      HALT  = 3'd4
   } state_t;

   state_t     state_reg, state_next;
   logic [7:0] ir_reg, ir_next;
   logic [7:0] operand_reg, operand_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         ir_reg      <= 8'h00;
         operand_reg <= 8'h00;
      end else begin
         state_reg   <= state_next;
         ir_reg      <= ir_next;
         operand_reg <= operand_next;
      end
   end

   // Every output is a decode of the current state and ir. The only input
   // that reaches an output is mem_ack, which reaches pc_mode during a fetch.
   // The counter increments whenever pc_mode is 0, so the idle default is
   // "load the current PC" (pc_mode=1, pc_sel=0). That default holds the PC.
   always_comb begin
      state_next   = state_reg;
      ir_next      = ir_reg;
      operand_next = operand_reg;
      mem_req      = 1'b0;
      pc_mode      = 1'b1;
      pc_sel       = 1'b0;
      pc_en_a      = 1'b0;
      pc_en_b      = 1'b0;
      alu_go       = 1'b0;
      ld_go        = 1'b0;

      case (state_reg)
         IDLE: begin
            if (run) state_next = FETCH;
         end

         FETCH: begin
            mem_req = 1'b1;
            pc_en_a = 1'b1;
            if (mem_ack) begin
               // The byte is accepted, so the PC steps to the next address.
               pc_mode = 1'b0;
               ir_next = mem_data;
               // LDI (01) and JMP (10) carry a second byte.
               if (mem_data[7:6] == 2'b01 || mem_data[7:6] == 2'b10)
                  state_next = OPND;
               else
                  state_next = EXEC;
            end
         end

         OPND: begin
            mem_req = 1'b1;
            pc_en_a = 1'b1;
            if (mem_ack) begin
               pc_mode      = 1'b0;
               operand_next = mem_data;
               state_next   = EXEC;
            end
         end

         EXEC: begin
            if (ir_reg == HALT_OP) begin
               state_next = HALT;
            end else begin
               if (ir_reg == GETPC_OP) pc_en_b = 1'b1;
               case (ir_reg[7:6])
                  2'b00:   alu_go = 1'b1;
                  2'b01:   ld_go  = 1'b1;
                  // The counter loads the operand at the edge that ends EXEC,
                  // so the jump target becomes the next fetch address.
                  2'b10:   pc_sel = 1'b1;
                  default: ;
               endcase
               state_next = run ? FETCH : IDLE;
            end
         end

         HALT: ;

         default: state_next = IDLE;
      endcase
   end

   assign ir      = ir_reg;
   assign operand = operand_reg;
   assign busy    = (state_reg != IDLE) && (state_reg != HALT);
   assign halted  = (state_reg == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer. The bench models the 8-bit program counter and a
// byte-wide memory that can insert per-address wait states. Stimulus pushes
// the expected fetches and execute cycles into queues. Monitor processes pop
// and compare those entries whenever the DUT accepts a byte or sits in an
// execute cycle.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       run = 1'b0;
   logic       mem_ack = 1'b0;
   logic [7:0] mem_data = 8'h00;
   logic       mem_req, pc_mode, pc_sel, pc_en_a, pc_en_b;
   logic [7:0] ir, operand;
   logic       alu_go, ld_go, busy, halted;

   pc_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .mem_ack  (mem_ack),
      .mem_data (mem_data),
      .mem_req  (mem_req),
      .pc_mode  (pc_mode),
      .pc_sel   (pc_sel),
      .pc_en_a  (pc_en_a),
      .pc_en_b  (pc_en_b),
      .ir       (ir),
      .operand  (operand),
      .alu_go   (alu_go),
      .ld_go    (ld_go),
      .busy     (busy),
      .halted   (halted)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Program counter model: increment on pc_mode=0, load operand on
   // pc_mode=1/pc_sel=1, otherwise hold. The bench can also preset the count.
   logic [7:0] pc = 8'h00;
   logic       force_en = 1'b0;
   logic [7:0] force_val = 8'h00;
   always @(posedge clk) begin
      if (force_en)     pc <= force_val;
      else if (!pc_mode) pc <= pc + 8'd1;
      else if (pc_sel)  pc <= operand;
   end

   int   cyc = 0;
   logic cyc_en = 1'b0;
   always @(posedge clk) if (cyc_en) cyc <= cyc + 1;

   // Memory model. Acks an address after wait_tab[addr] stall cycles.
   // Outside a request it drives ack_noise instead.
   logic [7:0] mem [256];
   int         wait_tab [256];
   int         req_cycles = 0;
   logic       ack_noise = 1'b0;
   always @(posedge clk) begin
      #2;
      if (mem_ack || !mem_req) req_cycles = 0;
      if (mem_req) begin
         if (req_cycles >= wait_tab[pc]) mem_ack = 1'b1;
         else begin
            mem_ack = 1'b0;
            req_cycles++;
         end
      end else begin
         mem_ack = ack_noise;
      end
      mem_data = mem[pc];
   end

   typedef struct {
      logic [7:0] addr;
      int         stalls;
   } fetch_t;

   typedef struct {
      logic [7:0] ir;
      logic [7:0] opnd;
      logic [3:0] strb;   // {alu_go, ld_go, pc_en_b, jump-load}
      logic [7:0] pc;
      int         cyc;    // 0 = cycle not checked
   } exec_t;

   fetch_t fq[$];
   exec_t  eq[$];

   task automatic pf(input logic [7:0] a, input int s);
      fetch_t f;
      f.addr   = a;
      f.stalls = s;
      fq.push_back(f);
   endtask

   task automatic pe(input logic [7:0] i, input logic [7:0] o, input logic [3:0] s,
                     input logic [7:0] p, input int c);
      exec_t e;
      e.ir   = i;
      e.opnd = o;
      e.strb = s;
      e.pc   = p;
      e.cyc  = c;
      eq.push_back(e);
   endtask

   localparam logic [3:0] S_ALU = 4'b1000, S_LD = 4'b0100, S_GETPC = 4'b0010,
                          S_JMP = 4'b0001, S_NONE = 4'b0000;

   // Monitor: accepted bytes and execute cycles.
   int stall_cnt = 0;
   always @(negedge clk) begin
      fetch_t f;
      exec_t  e;
      check("bus_excl", {63'd0, pc_en_a & pc_en_b}, 64'd0);
      if (mem_req) begin
         check("fetch_en_a", {63'd0, pc_en_a}, 64'd1);
         check("fetch_mode", {63'd0, pc_mode}, {63'd0, !mem_ack});
         if (mem_ack) begin
            if (fq.size() == 0) fail_now("fetch_unexpected");
            else begin
               f = fq.pop_front();
               check("fetch_addr", {56'd0, pc}, {56'd0, f.addr});
               check("fetch_stalls", stall_cnt, f.stalls);
            end
            stall_cnt = 0;
         end else begin
            stall_cnt++;
         end
      end else begin
         stall_cnt = 0;
      end

      if (busy && !mem_req) begin
         if (eq.size() == 0) fail_now("exec_unexpected");
         else begin
            e = eq.pop_front();
            check("exec_ir_opnd_strb_pc",
                  {36'd0, ir, operand, alu_go, ld_go, pc_en_b, pc_mode & pc_sel, pc},
                  {36'd0, e.ir, e.opnd, e.strb, e.pc});
            if (e.cyc != 0) check("exec_cycle", cyc, e.cyc);
         end
      end else begin
         check("no_stray_strobe", {61'd0, alu_go, ld_go, pc_en_b}, 64'd0);
      end
   end

   task automatic check_reset(input string tag);
      check({tag, "_mem_req"}, {63'd0, mem_req}, 64'd0);
      check({tag, "_pc_mode"}, {63'd0, pc_mode}, 64'd1);
      check({tag, "_pc_sel"},  {63'd0, pc_sel},  64'd0);
      check({tag, "_pc_en_a"}, {63'd0, pc_en_a}, 64'd0);
      check({tag, "_pc_en_b"}, {63'd0, pc_en_b}, 64'd0);
      check({tag, "_alu_go"},  {63'd0, alu_go},  64'd0);
      check({tag, "_ld_go"},   {63'd0, ld_go},   64'd0);
      check({tag, "_busy"},    {63'd0, busy},    64'd0);
      check({tag, "_halted"},  {63'd0, halted},  64'd0);
      check({tag, "_ir"},      {56'd0, ir},      64'd0);
      check({tag, "_operand"}, {56'd0, operand}, 64'd0);
   endtask

   task automatic force_pc(input logic [7:0] v);
      @(negedge clk);
      force_en  = 1'b1;
      force_val = v;
      @(negedge clk);
      force_en  = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]      = 8'h00;
         wait_tab[i] = 0;
      end
      // Program: ALU, GETPC, LDI 4A, JMP 10 -> JMP 80 -> ALU (3 waits), NOP, HALT
      mem[8'h00] = 8'h05;
      mem[8'h01] = 8'hFE;
      mem[8'h02] = 8'h40;  mem[8'h03] = 8'h4A;
      mem[8'h04] = 8'h80;  mem[8'h05] = 8'h10;
      mem[8'h10] = 8'h80;  mem[8'h11] = 8'h80;
      mem[8'h80] = 8'h20;  wait_tab[8'h80] = 3;
      mem[8'h81] = 8'hC3;
      mem[8'h82] = 8'hFF;

      // Reset state
      repeat (2) @(negedge clk);
      #1 check_reset("reset0");
      @(negedge clk);
      rst = 1'b1;

      // Phase 1: zero-wait program with one wait-state fetch, ending in HALT
      pf(8'h00, 0); pe(8'h05, 8'h00, S_ALU,   8'h01, 2);
      pf(8'h01, 0); pe(8'hFE, 8'h00, S_GETPC, 8'h02, 4);
      pf(8'h02, 0); pf(8'h03, 0); pe(8'h40, 8'h4A, S_LD,  8'h04, 7);
      pf(8'h04, 0); pf(8'h05, 0); pe(8'h80, 8'h10, S_JMP, 8'h06, 10);
      pf(8'h10, 0); pf(8'h11, 0); pe(8'h80, 8'h80, S_JMP, 8'h12, 13);
      pf(8'h80, 3); pe(8'h20, 8'h80, S_ALU,  8'h81, 18);
      pf(8'h81, 0); pe(8'hC3, 8'h80, S_NONE, 8'h82, 20);
      pf(8'h82, 0); pe(8'hFF, 8'h80, S_NONE, 8'h83, 22);
      @(negedge clk);
      run    = 1'b1;
      cyc_en = 1'b1;
      for (int i = 0; i < 100 && !halted; i++) @(negedge clk);
      check("halt_reached", {63'd0, halted}, 64'd1);

      // HALT holds with run=1 and ack toggling
      for (int i = 0; i < 20; i++) begin
         ack_noise = ~ack_noise;
         @(negedge clk);
         check("halt_pc", {56'd0, pc}, 64'h83);
         check("halt_flags", {61'd0, halted, busy, mem_req}, 64'b100);
      end
      ack_noise = 1'b0;
      #1 rst = 1'b0;
      #1 check_reset("reset_after_halt");
      run    = 1'b0;
      cyc_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Phase 2: run dropped while waiting on the operand byte
      mem[8'h30] = 8'h41;
      mem[8'h31] = 8'h99;  wait_tab[8'h31] = 2;
      force_pc(8'h30);
      pf(8'h30, 0); pf(8'h31, 2); pe(8'h41, 8'h99, S_LD, 8'h32, 0);
      @(negedge clk);
      run = 1'b1;
      for (int i = 0; i < 50 && !(mem_req && pc == 8'h31); i++) @(negedge clk);
      check("opnd_wait_reached", {63'd0, mem_req && pc == 8'h31}, 64'd1);
      run = 1'b0;
      repeat (8) @(negedge clk);
      check("idle_after_drop", {61'd0, busy, mem_req, halted}, 64'd0);

      // Phase 3: asynchronous reset in the middle of a fetch
      mem[8'h40] = 8'h00;  wait_tab[8'h40] = 5;
      force_pc(8'h40);
      @(negedge clk);
      run = 1'b1;
      for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
      check("fetch_started", {63'd0, mem_req}, 64'd1);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      #1;
      check("async_mem_req", {63'd0, mem_req}, 64'd0);
      check("async_ir", {56'd0, ir}, 64'd0);
      check("async_busy", {63'd0, busy}, 64'd0);
      run = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Phase 4: PC wrap FF -> 00 on a 1-byte NOP
      mem[8'hFF] = 8'hC0;
      force_pc(8'hFF);
      pf(8'hFF, 0); pe(8'hC0, 8'h00, S_NONE, 8'h00, 0);
      pf(8'h00, 0); pe(8'h05, 8'h00, S_ALU,  8'h01, 0);
      @(negedge clk);
      run = 1'b1;
      for (int i = 0; i < 50 && pc != 8'h01; i++) @(negedge clk);
      check("wrap_reached", {56'd0, pc}, 64'h01);
      run = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_after_wrap", {61'd0, busy, mem_req, halted}, 64'd0);

      check("fetch_queue_empty", fq.size(), 64'd0);
      check("exec_queue_empty", eq.size(), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
